address_translation_table: RTL and testbench
============================================

ADDRESS_TRANSLATION_TABLE -- requirements
Module: address_translation_table

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, width of logical router addresses.
REQ-002 The block SHALL have parameter NUM_ROUTERS, default 16, number of table entries (physical router indices).
REQ-003 The block SHALL have parameter IDX_WIDTH, default 4, width of a physical index; integrator guarantees 2**IDX_WIDTH >= NUM_ROUTERS.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port cfg_wr_en, input, 1, table write strobe.
REQ-007 The block SHALL have port cfg_wr_idx, input, IDX_WIDTH, entry written.
REQ-008 The block SHALL have port cfg_wr_addr, input, ADDR_WIDTH, logical address stored in the entry.
REQ-009 The block SHALL have port cfg_clr_all, input, 1, invalidate all entries.
REQ-010 The block SHALL have port lookup_valid, input, 1, lookup request present.
REQ-011 The block SHALL have port lookup_ready, output, 1, block can accept a lookup.
REQ-012 The block SHALL have port lookup_addr, input, ADDR_WIDTH, logical address to translate.
REQ-013 The block SHALL have port result_valid, output, 1, result present.
REQ-014 The block SHALL have port result_ready, input, 1, consumer accepts result.
REQ-015 The block SHALL have port result_idx, output, IDX_WIDTH, translated physical index.
REQ-016 The block SHALL have port result_hit, output, 1, 1 = match found, 0 = miss.
REQ-017 The block SHALL have port miss_count, output, 16, saturating count of miss results delivered.

Function
REQ-018 The table SHALL hold NUM_ROUTERS entries, each an ADDR_WIDTH address plus a valid bit.
REQ-019 cfg_wr_en with cfg_wr_idx < NUM_ROUTERS SHALL load cfg_wr_addr and set valid on that entry at the next edge; cfg_wr_idx >= NUM_ROUTERS SHALL be ignored.
REQ-020 cfg_clr_all SHALL clear every valid bit at the next edge; addresses are unchanged.
REQ-021 cfg_clr_all and cfg_wr_en in the same cycle: clear applies first, the written entry ends valid.
REQ-022 A lookup SHALL be accepted on an edge where lookup_valid and lookup_ready are both 1.
REQ-023 lookup_ready SHALL equal (!result_valid || result_ready), combinationally.
REQ-024 An accepted lookup SHALL produce result_valid=1 on the following cycle (latency 1) with result_idx and result_hit registered.
REQ-025 Matching SHALL compare lookup_addr against valid entries only, using table contents before any same-edge config write.
REQ-026 Multiple matching entries: the lowest index SHALL win.
REQ-027 No match: result_hit=0 and result_idx=0.
REQ-028 result_valid, result_idx, result_hit SHALL hold stable while result_valid=1 and result_ready=0.
REQ-029 Result consumed with no new accept: result_valid SHALL fall to 0 next cycle; consume plus accept on the same edge: new result loads, no bubble.
REQ-030 miss_count SHALL increment by 1 on each edge where a result with result_hit=0 is consumed (result_valid && result_ready), and saturate at 16'hFFFF.

Reset
REQ-031 While rst=1: all valid bits 0, all entry addresses 0, result_valid=0, result_idx=0, result_hit=0, miss_count=0; lookup_ready=1 as a consequence.
REQ-032 Reset asserted mid-operation SHALL discard any pending result and all table contents immediately, without waiting for clk.

Verification
REQ-033 After reset, write idx0=0xC, idx1=0xA, idx2=0x8; lookup 0xA with result_ready=1 -> next cycle result_valid=1, result_idx=1, result_hit=1.
REQ-034 Write idx3=0x8 and idx5=0x8; lookup 0x8 -> result_idx=2, hit=1 (lowest index wins); invalidate via cfg_clr_all then rewrite only idx5=0x8 -> result_idx=5.
REQ-035 Lookup 0x5 on a table without 0x5 -> result_hit=0, result_idx=0, miss_count increments from 0 to 1 on consume.
REQ-036 Hold result_ready=0 for 3 cycles with lookup_valid=1 -> lookup_ready=0, result fields stable, no lookups accepted; release -> back-to-back results at one per cycle.
REQ-037 Same-edge cfg write idx4=0x3 and lookup 0x3 (table lacking 0x3) -> result_hit=0; lookup 0x3 again next cycle -> result_idx=4, hit=1.
REQ-038 Assert rst asynchronously between edges while result_valid=1 -> result_valid, miss_count, all valid bits go 0 before the next clk edge.

Source files
------------

// File: rtl/address_translation_table.sv
// Logical-to-physical router address translation table.
// Configurable entries with a single-entry valid/ready lookup pipeline and a miss counter.
module address_translation_table #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned NUM_ROUTERS = 16,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]  cfg_wr_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic                  cfg_clr_all,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [IDX_WIDTH-1:0]  result_idx,
  output logic                  result_hit,
  output logic [15:0]           miss_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0]  addr_q [NUM_ROUTERS];
  logic [ADDR_WIDTH-1:0]  addr_d [NUM_ROUTERS];
  logic [NUM_ROUTERS-1:0] valid_q, valid_d;

  logic                   result_valid_q, result_valid_d;
  logic [IDX_WIDTH-1:0]   result_idx_q, result_idx_d;
  logic                   result_hit_q, result_hit_d;
  logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;

  logic                   match_hit_c;
  logic [IDX_WIDTH-1:0]   match_idx_c;
  logic                   accept_c;
  logic                   consume_c;

  assign lookup_ready = !result_valid_q || result_ready;
  assign accept_c     = lookup_valid && lookup_ready;
  assign consume_c    = result_valid_q && result_ready;

  // Priority match on pre-write contents; descending scan leaves the lowest index.
  always_comb begin
    match_hit_c = 1'b0;
    match_idx_c = '0;
    for (int i = int'(NUM_ROUTERS) - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
        match_hit_c = 1'b1;
        match_idx_c = IDX_WIDTH'(i);
      end
    end
  end

  // Clear is applied before the write so a simultaneous write survives.
  // Indices at or above NUM_ROUTERS never compare equal and are dropped.
  always_comb begin
    addr_d  = addr_q;
    valid_d = cfg_clr_all ? '0 : valid_q;
    for (int i = 0; i < int'(NUM_ROUTERS); i++) begin
      if (cfg_wr_en && (cfg_wr_idx == IDX_WIDTH'(i))) begin
        addr_d[i]  = cfg_wr_addr;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    result_valid_d = result_valid_q;
    result_idx_d   = result_idx_q;
    result_hit_d   = result_hit_q;
    miss_count_d   = miss_count_q;
    if (consume_c && !result_hit_q && (miss_count_q != CNT_MAX)) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end
    if (accept_c) begin
      result_valid_d = 1'b1;
      result_idx_d   = match_idx_c;
      result_hit_d   = match_hit_c;
    end else if (consume_c) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ROUTERS); i++) begin
        addr_q[i] <= '0;
      end
      valid_q        <= '0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      result_hit_q   <= 1'b0;
      miss_count_q   <= '0;
    end else begin
      addr_q         <= addr_d;
      valid_q        <= valid_d;
      result_valid_q <= result_valid_d;
      result_idx_q   <= result_idx_d;
      result_hit_q   <= result_hit_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result_idx   = result_idx_q;
  assign result_hit   = result_hit_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_address_translation_table.sv
// Directed vector bench for address_translation_table with hand-computed expectations.
module tb_address_translation_table;

  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;
  localparam int unsigned IW = 4;
  localparam int NV = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [IW-1:0] cfg_wr_idx;
  logic [AW-1:0] cfg_wr_addr;
  logic          cfg_clr_all;
  logic          lookup_valid;
  logic          lookup_ready;
  logic [AW-1:0] lookup_addr;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_idx;
  logic          result_hit;
  logic [15:0]   miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] wr_addr;
    logic          clr;
    logic          lv;
    logic [AW-1:0] la;
    logic          rr;
    logic          exp_rv;
    logic [IW-1:0] exp_idx;
    logic          exp_hit;
    logic [15:0]   exp_miss;
    logic          exp_rdy;
  } vec_t;

  vec_t vecs [NV];

  address_translation_table #(
    .ADDR_WIDTH (AW),
    .NUM_ROUTERS(NR),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_idx  (cfg_wr_idx),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_clr_all (cfg_clr_all),
    .lookup_valid(lookup_valid),
    .lookup_ready(lookup_ready),
    .lookup_addr (lookup_addr),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_idx  (result_idx),
    .result_hit  (result_hit),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cfg_wr_en    = v.wr_en;
    cfg_wr_idx   = v.wr_idx;
    cfg_wr_addr  = v.wr_addr;
    cfg_clr_all  = v.clr;
    lookup_valid = v.lv;
    lookup_addr  = v.la;
    result_ready = v.rr;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " result_valid"}, 32'(result_valid), 32'(v.exp_rv));
    check({tag, " miss_count"}, 32'(miss_count), 32'(v.exp_miss));
    check({tag, " lookup_ready"}, 32'(lookup_ready), 32'(v.exp_rdy));
    if (v.exp_rv) begin
      check({tag, " result_idx"}, 32'(result_idx), 32'(v.exp_idx));
      check({tag, " result_hit"}, 32'(result_hit), 32'(v.exp_hit));
    end
  endtask

  initial begin
    // {wr_en, wr_idx, wr_addr, clr, lv, la, rr, exp_rv, exp_idx, exp_hit, exp_miss, exp_rdy}
    vecs[0]  = '{1'b1, 4'd0,  4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'd1,  4'hA, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd0, 1'b1};
    vecs[2]  = '{1'b1, 4'd2,  4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 4'd1,  1'b1, 16'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'd3,  4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd2,  1'b1, 16'd0, 1'b1};
    vecs[5]  = '{1'b1, 4'd5,  4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd2,  1'b1, 16'd0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  4'h0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 4'd2,  1'b1, 16'd0, 1'b1};
    vecs[7]  = '{1'b1, 4'd5,  4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd0, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd5,  1'b1, 16'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'd0,  1'b0, 16'd0, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd5,  1'b1, 16'd1, 1'b1};
    vecs[11] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd1, 1'b1};
    vecs[12] = '{1'b1, 4'd4,  4'h3, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 4'd0,  1'b0, 16'd1, 1'b1};
    vecs[13] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 4'd4,  1'b1, 16'd2, 1'b1};
    vecs[14] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 4'd4,  1'b1, 16'd2, 1'b0};
    vecs[15] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 4'd4,  1'b1, 16'd2, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 4'd4,  1'b1, 16'd2, 1'b0};
    vecs[17] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd5,  1'b1, 16'd2, 1'b1};
    vecs[18] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 4'd4,  1'b1, 16'd2, 1'b1};
    vecs[19] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'd0,  1'b0, 16'd2, 1'b1};
    vecs[20] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'd0,  1'b0, 16'd2, 1'b0};
    vecs[21] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd3, 1'b1};
    vecs[22] = '{1'b1, 4'd15, 4'hE, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0,  1'b0, 16'd3, 1'b1};
    vecs[23] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 4'd15, 1'b1, 16'd3, 1'b1};
    vecs[24] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'd5,  1'b1, 16'd3, 1'b1};

    rst = 1'b1;
    drive('{1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result_idx", 32'(result_idx), 32'd0);
    check("reset result_hit", 32'(result_hit), 32'd0);
    check("reset miss_count", 32'(miss_count), 32'd0);
    check("reset lookup_ready", 32'(lookup_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset between edges while a result is pending and miss_count is nonzero.
    @(negedge clk);
    drive('{1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0, 1'b1});
    #2;
    check("pre_rst result_valid", 32'(result_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst result_valid", 32'(result_valid), 32'd0);
    check("async_rst miss_count", 32'(miss_count), 32'd0);
    check("async_rst lookup_ready", 32'(lookup_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table must be empty: previously valid 0x8 and reset-value address 0x0 both miss.
    @(negedge clk);
    drive('{1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b1});
    @(posedge clk);
    #1;
    check("post_rst lookup8 valid", 32'(result_valid), 32'd1);
    check("post_rst lookup8 hit", 32'(result_hit), 32'd0);
    check("post_rst lookup8 idx", 32'(result_idx), 32'd0);
    @(negedge clk);
    lookup_addr = 4'h0;
    @(posedge clk);
    #1;
    check("post_rst lookup0 hit", 32'(result_hit), 32'd0);
    check("post_rst miss_count", 32'(miss_count), 32'd1);
    @(negedge clk);
    lookup_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst drain valid", 32'(result_valid), 32'd0);
    check("post_rst drain miss_count", 32'(miss_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
